// File: rtl/best_root_ctrl.sv
// Training-loop controller: tracks least valid error, snapshots weights on improvement.
// Optional BEST_ROOT_PATIENCE_EN adds a no-improvement patience stop.
module best_root_ctrl #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int EXTRA         = 2,
  parameter int NUM_UNKNOWNS  = 2,
  parameter int ADDR_W        = 4,
  parameter int ITER_W        = 16,
  parameter int MAX_ITER      = 1000
`ifdef BEST_ROOT_PATIENCE_EN
  ,
  parameter int PATIENCE      = 64
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [ELEMENT_WIDTH+EXTRA-1:0] tol,
  input  logic                          err_valid,
  input  logic [ELEMENT_WIDTH+EXTRA-1:0] current_err,
  output logic [ADDR_W-1:0]             src_rd_addr,
  input  logic [ELEMENT_WIDTH-1:0]      src_rd_data,
  output logic                          best_wr_en,
  output logic [ADDR_W-1:0]             best_wr_addr,
  output logic [ELEMENT_WIDTH-1:0]      best_wr_data,
  output logic                          stall_train,
  output logic [ELEMENT_WIDTH+EXTRA-1:0] best_error,
  output logic                          best_valid,
  output logic [ITER_W-1:0]             iter_count,
  output logic                          busy,
  output logic                          done,
  output logic                          converged
);

  localparam int EW = ELEMENT_WIDTH + EXTRA;
  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NUM_UNKNOWNS - 1);
  localparam logic [ITER_W-1:0] MAX_V  = ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_COPY,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] k_q;
  logic [ITER_W-1:0] iter_q;
  logic [EW-1:0]     best_q;
  logic              bv_q;
  logic              conv_q;
  logic              cand;
  logic              tol_hit;
  logic              pat_hit;

  assign cand = !current_err[ELEMENT_WIDTH-1] &&
                (!bv_q || current_err < best_q);
  assign tol_hit = bv_q && (best_q <= tol);

`ifdef BEST_ROOT_PATIENCE_EN
  localparam logic [ITER_W-1:0] PAT_V = ITER_W'(PATIENCE);
  logic [ITER_W-1:0] pat_q;
  assign pat_hit = (pat_q == PAT_V);
`else
  assign pat_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE,
      S_DONE: begin
        if (start) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (err_valid) state_d = cand ? S_COPY : S_CHECK;
      end
      S_COPY: begin
        if (k_q == LAST_K) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (tol_hit)              state_d = S_DONE;
        else if (pat_hit)         state_d = S_DONE;
        else if (iter_q == MAX_V) state_d = S_DONE;
        else                      state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Run state holds across abort; only a fresh start clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q    <= '0;
      iter_q <= '0;
      best_q <= '0;
      bv_q   <= 1'b0;
      conv_q <= 1'b0;
    end else if (!abort) begin
      unique case (state_q)
        S_IDLE,
        S_DONE: begin
          if (start) begin
            iter_q <= '0;
            best_q <= '0;
            bv_q   <= 1'b0;
            conv_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (err_valid) begin
            iter_q <= iter_q + 1'b1;
            if (cand) begin
              best_q <= current_err;
              bv_q   <= 1'b1;
              k_q    <= '0;
            end
          end
        end
        S_COPY: begin
          k_q <= k_q + 1'b1;
        end
        S_CHECK: begin
          if (tol_hit) conv_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BEST_ROOT_PATIENCE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= '0;
    end else if (!abort) begin
      if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
        pat_q <= '0;
      end else if (state_q == S_WAIT && err_valid) begin
        pat_q <= cand ? '0 : pat_q + 1'b1;
      end
    end
  end
`endif

  assign best_wr_en   = (state_q == S_COPY);
  assign best_wr_addr = best_wr_en ? k_q : '0;
  assign src_rd_addr  = best_wr_addr;
  assign best_wr_data = src_rd_data;
  assign stall_train  = (state_q == S_COPY) || (state_q == S_CHECK);
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign best_error   = best_q;
  assign best_valid   = bv_q;
  assign iter_count   = iter_q;
  assign converged    = conv_q;

endmodule

// File: tb/tb_best_root_ctrl.sv
// Scoreboard bench for best_root_ctrl: expected weight writes queued at stimulus.
// Exercises BEST_ROOT_PATIENCE_EN when that macro is defined.
module tb_best_root_ctrl;

  localparam int EW = 34;
  localparam int N  = 3;
  localparam int MX = 4;
`ifdef BEST_ROOT_PATIENCE_EN
  localparam bit PAT_ON = 1'b1;
`else
  localparam bit PAT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [EW-1:0] tol;
  logic          err_valid;
  logic [EW-1:0] current_err;
  logic [3:0]    src_rd_addr;
  logic [31:0]   src_rd_data;
  logic          best_wr_en;
  logic [3:0]    best_wr_addr;
  logic [31:0]   best_wr_data;
  logic          stall_train;
  logic [EW-1:0] best_error;
  logic          best_valid;
  logic [15:0]   iter_count;
  logic          busy;
  logic          done;
  logic          converged;

  logic [31:0] wmem [16];
  logic [35:0] wq [$];

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int exp_stall;

  logic [EW-1:0] m_be;
  bit            m_bv;
  int            m_it;
  int            m_pat;
  bit            m_done;
  bit            m_conv;

  always #5 clk = ~clk;

  assign src_rd_data = wmem[src_rd_addr];

  best_root_ctrl #(
    .ELEMENT_WIDTH(32),
    .EXTRA(2),
    .NUM_UNKNOWNS(N),
    .ADDR_W(4),
    .ITER_W(16),
    .MAX_ITER(MX)
`ifdef BEST_ROOT_PATIENCE_EN
    ,
    .PATIENCE(2)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .tol(tol),
    .err_valid(err_valid),
    .current_err(current_err),
    .src_rd_addr(src_rd_addr),
    .src_rd_data(src_rd_data),
    .best_wr_en(best_wr_en),
    .best_wr_addr(best_wr_addr),
    .best_wr_data(best_wr_data),
    .stall_train(stall_train),
    .best_error(best_error),
    .best_valid(best_valid),
    .iter_count(iter_count),
    .busy(busy),
    .done(done),
    .converged(converged)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && best_wr_en) begin
      if (wq.size() == 0) begin
        chk("wr_extra", {28'd0, best_wr_addr, best_wr_data}, 64'd0);
      end else begin
        chk("wr", {28'd0, best_wr_addr, best_wr_data},
            {28'd0, wq.pop_front()});
      end
    end
    if (!rst && stall_train) stall_cnt++;
  end

  task automatic wait_rdy();
    int n = 0;
    while (!(busy && !stall_train) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("rdy_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_end();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("end_timeout", 64'd1, 64'd0);
  endtask

  task automatic go(input logic [EW-1:0] t);
    @(negedge clk);
    tol = t;
    for (int i = 0; i < 16; i++) wmem[i] = $urandom;
    m_be = '0;
    m_bv = 0;
    m_it = 0;
    m_pat = 0;
    m_done = 0;
    m_conv = 0;
    exp_stall = 0;
    stall_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [EW-1:0] e, input bit junk,
                      input int nwr);
    bit imp;
    wait_rdy();
    imp = !e[31] && (!m_bv || e < m_be);
    m_it++;
    exp_stall++;
    if (imp) begin
      for (int k = 0; k < N; k++)
        if (k < nwr) wq.push_back({4'(k), wmem[k]});
      m_be = e;
      m_bv = 1;
      m_pat = 0;
      exp_stall += N;
    end else begin
      m_pat++;
    end
    if (m_bv && m_be <= tol) begin
      m_done = 1;
      m_conv = 1;
    end else if (PAT_ON && m_pat == 2) begin
      m_done = 1;
    end else if (m_it == MX) begin
      m_done = 1;
    end
    err_valid = 1'b1;
    current_err = e;
    @(negedge clk);
    if (junk) begin
      current_err = 34'h1;
      repeat (imp ? N + 1 : 1) @(negedge clk);
    end
    err_valid = 1'b0;
  endtask

  task automatic chk_run(input string tag);
    chk({tag, "_be"}, 64'(best_error), 64'(m_be));
    chk({tag, "_bv"}, 64'(best_valid), 64'(m_bv));
    chk({tag, "_it"}, 64'(iter_count), 64'(m_it));
    chk({tag, "_done"}, 64'(done), 64'(m_done));
    if (m_done) chk({tag, "_conv"}, 64'(converged), 64'(m_conv));
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_it0"}, 64'(iter_count), 64'd0);
    chk({tag, "_bv0"}, 64'(best_valid), 64'd0);
    chk({tag, "_be0"}, 64'(best_error), 64'd0);
    chk({tag, "_cv0"}, 64'(converged), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    tol = '0;
    err_valid = 1'b0;
    current_err = '0;
    for (int i = 0; i < 16; i++) wmem[i] = $urandom;
    repeat (2) @(negedge clk);
    chk("rst_wren", 64'(best_wr_en), 64'd0);
    chk("rst_addr", 64'(best_wr_addr), 64'd0);
    chk("rst_raddr", 64'(src_rd_addr), 64'd0);
    chk("rst_wdata", 64'(best_wr_data), 64'(wmem[0]));
    chk("rst_flags", {59'd0, stall_train, best_valid, busy, done, converged},
        64'd0);
    chk("rst_be", 64'(best_error), 64'd0);
    chk("rst_it", 64'(iter_count), 64'd0);
    rst = 1'b0;

    // two improvements then a worse sample; MAX_ITER ends run on sample 4
    go(34'h10);
    chk_clear("a_clr");
    send(34'h200, 1'b0, N);
    send(34'h100, 1'b0, N);
    send(34'h180, 1'b0, N);
    wait_rdy();
    chk_run("a3");
    chk("a_stall", 64'(stall_cnt), 64'(exp_stall));
    send(34'h300, 1'b0, N);
    wait_end();
    chk_run("a_end");
    repeat (3) @(negedge clk);
    chk("a_hold_done", 64'(done), 64'd1);
    chk("a_hold_it", 64'(iter_count), 64'(m_it));

    // sign-bit sample rejected; junk err_valid in COPY/CHECK ignored
    go(34'h40);
    chk_clear("b_clr");
    send(34'h0_8000_0005, 1'b1, N);
    wait_rdy();
    chk_run("b1");
    send(34'h50, 1'b1, N);
    wait_rdy();
    chk_run("b2");
    send(34'h40, 1'b1, N);
    wait_end();
    chk_run("b_end");
    chk("b_stall", 64'(stall_cnt), 64'(exp_stall));
    repeat (4) @(negedge clk);
    chk("b_hold", {62'd0, done, converged}, 64'd3);

    // equal error is no improvement
    go(34'h0);
    chk_clear("c_clr");
    while (!m_done && m_it < 10) send(34'h100, 1'b0, N);
    wait_end();
    chk_run("c_end");
    chk("c_stall", 64'(stall_cnt), 64'(exp_stall));

    // abort on the second copy cycle
    go(34'h0);
    send(34'h77, 1'b0, 2);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("d_flags", {60'd0, busy, done, stall_train, best_wr_en}, 64'd0);
    chk_run("d_ab");
    err_valid = 1'b1;
    current_err = 34'h1;
    @(negedge clk);
    err_valid = 1'b0;
    @(negedge clk);
    chk_run("d_idle");
    chk("d_busy", 64'(busy), 64'd0);

    // async reset mid-copy
    go(34'h0);
    send(34'h33, 1'b0, 1);
    #2 rst = 1'b1;
    #1;
    chk("e_flags", {59'd0, stall_train, best_valid, busy, done, best_wr_en},
        64'd0);
    chk("e_be", 64'(best_error), 64'd0);
    chk("e_it", 64'(iter_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    chk("wq_left", 64'(wq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/best_root_ctrl.md
Name: best_root_ctrl

Overview:
- Training-loop controller that sequences error evaluation and best-root capture for the NN non-linear-equation solver.
- Consumes per-iteration error samples and tracks the least valid error.
- On each improvement, copies all NUM_UNKNOWNS working weights into the best-weights memory while stalling the training datapath.
- Terminates training on convergence (error <= tolerance) or on reaching the iteration limit.

Parameters:
- ELEMENT_WIDTH, 32, weight word width.
- EXTRA, 2, extra error guard bits; error width EW = ELEMENT_WIDTH+EXTRA.
- NUM_UNKNOWNS, 2, number of weights (roots) copied per improvement; must be >= 1.
- ADDR_W, 4, address width; 2^ADDR_W >= NUM_UNKNOWNS.
- ITER_W, 16, iteration counter width.
- MAX_ITER, 1000, iteration limit; 1 <= MAX_ITER <= 2^ITER_W-1.

Ports:
- clk input 1 clock, rising edge.
- rst input 1 asynchronous, active-high reset.
- start input 1 one-cycle pulse; starts a run from IDLE or DONE; ignored otherwise.
- abort input 1 synchronous return to IDLE from any state; has priority over all other inputs.
- tol input EW convergence tolerance, unsigned; sampled in CHECK.
- err_valid input 1 current_err valid this cycle.
- current_err input EW error sample.
- src_rd_addr output ADDR_W read address into the working-weights memory.
- src_rd_data input ELEMENT_WIDTH working-weight data; combinational read of src_rd_addr.
- best_wr_en output 1 write strobe to the best-weights memory.
- best_wr_addr output ADDR_W write address.
- best_wr_data output ELEMENT_WIDTH write data; equals src_rd_data.
- stall_train output 1 freezes the training datapath.
- best_error output EW least valid error so far.
- best_valid output 1 best_error holds a real sample.
- iter_count output ITER_W accepted error samples in this run.
- busy output 1 state is not IDLE and not DONE.
- done output 1 high in DONE.
- converged output 1 run ended by tolerance; valid while done=1.

Behaviour:
- Reset: state=IDLE; every output 0 except best_wr_data, which follows src_rd_data.
- Candidate rule: current_err[ELEMENT_WIDTH-1]==0 (sign bit clear) AND (best_valid==0 OR current_err < best_error), compared unsigned over the full EW bits. No sentinel values are used.
- IDLE:
  - start -> WAIT_ERR next cycle.
  - Same transition clears iter_count, best_valid, best_error and converged.
- WAIT_ERR:
  - err_valid=1 -> iter_count++.
  - If candidate: best_error<=current_err, best_valid<=1, copy index<=0, -> COPY.
  - Otherwise -> CHECK.
- COPY:
  - Lasts exactly NUM_UNKNOWNS cycles; copy index k=0..NUM_UNKNOWNS-1.
  - Each cycle: best_wr_en=1, src_rd_addr=best_wr_addr=k.
  - After k==NUM_UNKNOWNS-1 -> CHECK.
  - Copy latency: the first write occurs 1 cycle after the improving sample.
- CHECK, one cycle, first match wins:
  - best_valid AND best_error<=tol -> DONE, converged=1.
  - iter_count==MAX_ITER -> DONE, converged=0.
  - else -> WAIT_ERR.
- DONE:
  - done=1; best_error, best_valid, iter_count and converged hold.
  - start -> WAIT_ERR with all run state cleared, as from IDLE.
- stall_train=1 in COPY and CHECK, 0 elsewhere.
- err_valid outside WAIT_ERR is ignored: no count, no compare.
- best_wr_en=0 outside COPY; best_wr_addr and src_rd_addr=0 outside COPY.
- abort: next cycle IDLE, best_wr_en=0, done=0, stall_train=0. A partial copy is abandoned; best_error and best_valid keep their last values until the next start.
- rst mid-copy: immediate return to reset values.
- Equal error (current_err==best_error) is not an improvement: no copy.

Optional Feature:
- Macro BEST_ROOT_PATIENCE_EN adds parameter PATIENCE (default 64).
- A counter counts consecutive accepted samples that are not candidates.
- It resets to 0 on any improvement and on start.
- In CHECK, after the tolerance test and before the MAX_ITER test: counter==PATIENCE -> DONE, converged=0.
- Without the macro: no counter, no PATIENCE parameter, termination by tolerance or MAX_ITER only.

Test Plan:
- Reset, start, tol=0x10, errors 0x200, 0x100, 0x180 -> copies (2 writes each, addr 0,1) after the 1st and 2nd samples only; best_error=0x100; iter_count=3; stall_train high for 3 cycles per copy, 1 cycle otherwise.
- Error 0x0_8000_0005 (bit31 set) as the first sample -> no copy, best_valid=0; next 0x50 -> copy, best_error=0x50.
- tol=0x40, errors 0x100 then 0x40 -> DONE after the second copy's CHECK; converged=1; done held until start.
- MAX_ITER=3, constant error 0x100, tol=0 -> one copy, DONE after the 3rd sample; converged=0; a later start clears iter_count and best_valid.
- abort asserted on the 2nd COPY cycle with NUM_UNKNOWNS=4 -> only addr 0,1 written; IDLE next cycle; err_valid pulses while in COPY, CHECK or IDLE are not counted.
- With BEST_ROOT_PATIENCE_EN and PATIENCE=2: errors 0x100, 0x200, 0x200 -> DONE, converged=0, iter_count=3.
